// File: rtl/apb_mr_bridge_if.sv
// Backend request port of the mode-register bridge, plus the internal APB3 bus
// that joins its master and slave halves.
interface apb_mr_bridge_if #(
  parameter int APB_ADDRWIDTH = 16,
  parameter int APB_DATAWIDTH = 8
);
  logic                     t;
  logic                     rd_wr;
  logic [3:0]               strb_i;
  logic [APB_ADDRWIDTH-1:0] m_addr_i;
  logic [APB_DATAWIDTH-1:0] m_wdata_i;
  logic [APB_DATAWIDTH-1:0] m_rdata_o;
  logic                     m_rvalid_o;

  modport master (
    output t, rd_wr, strb_i, m_addr_i, m_wdata_i,
    input  m_rdata_o, m_rvalid_o
  );

  modport slave (
    input  t, rd_wr, strb_i, m_addr_i, m_wdata_i,
    output m_rdata_o, m_rvalid_o
  );
endinterface

interface apb3_if #(
  parameter int APB_ADDRWIDTH = 16,
  parameter int APB_DATAWIDTH = 8
);
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [APB_ADDRWIDTH-1:0] paddr;
  logic [APB_DATAWIDTH-1:0] pwdata;
  logic [3:0]               pstrb;
  logic                     pready;
  logic [APB_DATAWIDTH-1:0] prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_mr_bridge.sv
// Mode-register command path: backend request -> APB3 master -> register-file
// slave that launches per-rank MRW/MRR requests and tracks their completion.
module apb_mr_bridge #(
  parameter int APB_ADDRWIDTH = 16,
  parameter int APB_DATAWIDTH = 8,
  parameter int NB_RANK       = 8
) (
  input  logic                mclk_i,
  input  logic                mrst_ni,
  apb_mr_bridge_if.slave      req,
  input  logic [NB_RANK-1:0]  mrw_done_status_i,
  input  logic [NB_RANK-1:0]  mrr_done_status_i,
  output logic [NB_RANK-1:0]  rank_mrw_o,
  output logic [NB_RANK-1:0]  rank_mrr_o
);
  logic w_pclk;
  logic w_prst_n;

  apb3_if #(.APB_ADDRWIDTH(APB_ADDRWIDTH), .APB_DATAWIDTH(APB_DATAWIDTH)) u_apb ();

  apb_master_port #(
    .APB_ADDRWIDTH(APB_ADDRWIDTH),
    .APB_DATAWIDTH(APB_DATAWIDTH)
  ) u_master (
    .mclk_i  (mclk_i),
    .mrst_ni (mrst_ni),
    .pclk_o  (w_pclk),
    .prst_no (w_prst_n),
    .req     (req),
    .apb     (u_apb.master)
  );

  apb_slave_port #(
    .APB_ADDRWIDTH(APB_ADDRWIDTH),
    .APB_DATAWIDTH(APB_DATAWIDTH),
    .NB_RANK      (NB_RANK)
  ) u_slave (
    .pclk_i            (w_pclk),
    .prst_ni           (w_prst_n),
    .apb               (u_apb.slave),
    .mrw_done_status_i (mrw_done_status_i),
    .mrr_done_status_i (mrr_done_status_i),
    .rank_mrw_o        (rank_mrw_o),
    .rank_mrr_o        (rank_mrr_o)
  );
endmodule

module apb_master_port #(
  parameter int APB_ADDRWIDTH = 16,
  parameter int APB_DATAWIDTH = 8
) (
  input  logic           mclk_i,
  input  logic           mrst_ni,
  output logic           pclk_o,
  output logic           prst_no,
  apb_mr_bridge_if.slave req,
  apb3_if.master         apb
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_pwrite;
  logic [APB_ADDRWIDTH-1:0] r_paddr;
  logic [APB_DATAWIDTH-1:0] r_pwdata;
  logic [3:0]               r_pstrb;
  logic [APB_DATAWIDTH-1:0] r_rdata;
  logic                     r_rvalid;
  logic                     w_done;
  logic                     w_sample;
  logic                     w_unused;

  assign pclk_o  = mclk_i;
  assign prst_no = mrst_ni;

  always_ff @(posedge mclk_i or negedge mrst_ni) begin
    if (!mrst_ni) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (req.t) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: if (apb.pready) w_state_next = req.t ? ST_SETUP : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    apb.psel    = (r_state != ST_IDLE);
    apb.penable = (r_state == ST_ACCESS);
  end

  // A new request is captured on entry to SETUP, whether from IDLE or back-to-back.
  assign w_done   = (r_state == ST_ACCESS) & apb.pready;
  assign w_sample = req.t & ((r_state == ST_IDLE) | w_done);

  always_ff @(posedge mclk_i or negedge mrst_ni) begin
    if (!mrst_ni) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_sample) begin
      r_pwrite <= req.rd_wr;
      r_paddr  <= req.m_addr_i;
      r_pwdata <= req.m_wdata_i;
      r_pstrb  <= req.strb_i;
    end
  end

  always_ff @(posedge mclk_i or negedge mrst_ni) begin
    if (!mrst_ni) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (w_done && !r_pwrite) begin
      r_rdata  <= apb.prdata;
      r_rvalid <= 1'b1;
    end else begin
      r_rvalid <= 1'b0;
    end
  end

  assign apb.pwrite     = r_pwrite;
  assign apb.paddr      = r_paddr;
  assign apb.pwdata     = r_pwdata;
  assign apb.pstrb      = r_pstrb;
  assign req.m_rdata_o  = r_rdata;
  assign req.m_rvalid_o = r_rvalid;
  assign w_unused       = apb.pslverr;
endmodule

module apb_slave_port #(
  parameter int APB_ADDRWIDTH = 16,
  parameter int APB_DATAWIDTH = 8,
  parameter int NB_RANK       = 8
) (
  input  logic               pclk_i,
  input  logic               prst_ni,
  apb3_if.slave              apb,
  input  logic [NB_RANK-1:0] mrw_done_status_i,
  input  logic [NB_RANK-1:0] mrr_done_status_i,
  output logic [NB_RANK-1:0] rank_mrw_o,
  output logic [NB_RANK-1:0] rank_mrr_o
);
  localparam int NB_LANE = APB_DATAWIDTH / 8;

  logic [APB_DATAWIDTH-1:0] r_mr_addr;
  logic [APB_DATAWIDTH-1:0] r_mr_data;
  logic [NB_RANK-1:0]       r_rank_mask;
  logic [NB_RANK-1:0]       r_mrr_rank_done;
  logic [NB_RANK-1:0]       r_rank_mrw;
  logic [NB_RANK-1:0]       r_rank_mrr;
  logic                     r_mrw_done;
  logic                     r_mrr_done;

  logic [APB_DATAWIDTH-1:0] w_bmask;
  logic [APB_DATAWIDTH-1:0] w_rdata;
  logic [NB_RANK-1:0]       w_mrw_next;
  logic [NB_RANK-1:0]       w_mrr_next;
  logic [NB_RANK-1:0]       w_mrr_rank_done_next;
  logic [1:0]               w_cmd;
  logic                     w_access;
  logic                     w_wr;
  logic                     w_addr_ok;
  logic                     w_sel_cmd;
  logic                     w_mrw_busy;
  logic                     w_mrr_busy;
  logic                     w_cmd_err;
  logic                     w_start_mrw;
  logic                     w_start_mrr;
  logic                     w_unused;

  // An all-zero strobe is a legacy APB3 write and updates every lane.
  for (genvar gi = 0; gi < NB_LANE; gi++) begin : g_lane
    assign w_bmask[gi*8 +: 8] = {8{(apb.pstrb == 4'b0000) | apb.pstrb[gi]}};
  end

  assign w_access   = apb.psel & apb.penable;
  assign w_wr       = w_access & apb.pwrite;
  assign w_addr_ok  = (apb.paddr <= APB_ADDRWIDTH'(4));
  assign w_sel_cmd  = (apb.paddr == APB_ADDRWIDTH'(2));
  assign w_cmd      = apb.pwdata[1:0] & w_bmask[1:0];
  assign w_mrw_busy = |r_rank_mrw;
  assign w_mrr_busy = |r_rank_mrr;

  assign w_cmd_err   = w_wr & w_sel_cmd & (w_cmd != 2'b00) &
                       ((w_cmd == 2'b11) | (r_rank_mask == '0) | w_mrw_busy | w_mrr_busy);
  assign w_start_mrw = w_wr & w_sel_cmd & (w_cmd == 2'b01) & !w_cmd_err;
  assign w_start_mrr = w_wr & w_sel_cmd & (w_cmd == 2'b10) & !w_cmd_err;

  // Done pulses only clear ranks that are still requested.
  assign w_mrw_next           = w_start_mrw ? r_rank_mask : (r_rank_mrw & ~mrw_done_status_i);
  assign w_mrr_next           = w_start_mrr ? r_rank_mask : (r_rank_mrr & ~mrr_done_status_i);
  assign w_mrr_rank_done_next = w_start_mrr ? '0 : (r_mrr_rank_done | (r_rank_mrr & mrr_done_status_i));

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      r_mr_addr       <= '0;
      r_mr_data       <= '0;
      r_rank_mask     <= '0;
      r_mrr_rank_done <= '0;
      r_rank_mrw      <= '0;
      r_rank_mrr      <= '0;
      r_mrw_done      <= 1'b0;
      r_mrr_done      <= 1'b0;
    end else begin
      if (w_wr) begin
        case (apb.paddr)
          APB_ADDRWIDTH'(0): r_mr_addr <= (r_mr_addr & ~w_bmask) | (apb.pwdata & w_bmask);
          APB_ADDRWIDTH'(1): r_mr_data <= (r_mr_data & ~w_bmask) | (apb.pwdata & w_bmask);
          APB_ADDRWIDTH'(3): r_rank_mask <= (r_rank_mask & ~w_bmask[NB_RANK-1:0]) |
                                            (apb.pwdata[NB_RANK-1:0] & w_bmask[NB_RANK-1:0]);
          default: ;
        endcase
      end
      r_rank_mrw      <= w_mrw_next;
      r_rank_mrr      <= w_mrr_next;
      r_mrr_rank_done <= w_mrr_rank_done_next;
      if (w_start_mrw)                            r_mrw_done <= 1'b0;
      else if (w_mrw_busy && (w_mrw_next == '0)) r_mrw_done <= 1'b1;
      if (w_start_mrr)                            r_mrr_done <= 1'b0;
      else if (w_mrr_busy && (w_mrr_next == '0)) r_mrr_done <= 1'b1;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (apb.paddr)
      APB_ADDRWIDTH'(0): w_rdata = r_mr_addr;
      APB_ADDRWIDTH'(1): w_rdata = r_mr_data;
      APB_ADDRWIDTH'(2): w_rdata[3:0] = {r_mrr_done, r_mrw_done, w_mrr_busy, w_mrw_busy};
      APB_ADDRWIDTH'(3): w_rdata[NB_RANK-1:0] = r_rank_mask;
      APB_ADDRWIDTH'(4): w_rdata[NB_RANK-1:0] = r_mrr_rank_done;
      default:           w_rdata = '0;
    endcase
  end

  assign apb.pready  = w_access;
  assign apb.prdata  = (w_access & !apb.pwrite) ? w_rdata : '0;
  assign apb.pslverr = w_access & (!w_addr_ok | w_cmd_err);
  assign rank_mrw_o  = r_rank_mrw;
  assign rank_mrr_o  = r_rank_mrr;
  assign w_unused    = ^apb.pstrb;
endmodule

// File: tb/tb_apb_mr_bridge.sv
// Directed bench for apb_mr_bridge: register access, MRW/MRR sequencing,
// command errors, strobes, reset abort and single-transfer request timing.
module tb_apb_mr_bridge;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] mrw_done = '0;
  logic [NR-1:0] mrr_done = '0;
  logic [NR-1:0] rank_mrw;
  logic [NR-1:0] rank_mrr;
  int            n_pass = 0;
  int            n_fail = 0;
  int            n_checks = 0;
  int            n_acc;

  apb_mr_bridge_if #(.APB_ADDRWIDTH(AW), .APB_DATAWIDTH(DW)) req_if ();

  apb_mr_bridge #(
    .APB_ADDRWIDTH(AW),
    .APB_DATAWIDTH(DW),
    .NB_RANK      (NR)
  ) dut (
    .mclk_i            (clk),
    .mrst_ni           (rst_n),
    .req               (req_if.slave),
    .mrw_done_status_i (mrw_done),
    .mrr_done_status_i (mrr_done),
    .rank_mrw_o        (rank_mrw),
    .rank_mrr_o        (rank_mrr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [3:0] strb,
                      output logic [DW-1:0] rdata, output logic slverr);
    @(negedge clk);
    req_if.t         = 1'b1;
    req_if.rd_wr     = wr;
    req_if.m_addr_i  = addr;
    req_if.m_wdata_i = wdata;
    req_if.strb_i    = strb;
    @(negedge clk);
    req_if.t = 1'b0;
    chk({tag, ".setup"}, 32'({dut.u_apb.psel, dut.u_apb.penable}), 32'h2);
    @(negedge clk);
    chk({tag, ".access"}, 32'({dut.u_apb.psel, dut.u_apb.penable, dut.u_apb.pready,
                               dut.u_apb.paddr == addr}), 32'hF);
    slverr = dut.u_apb.pslverr;
    @(negedge clk);
    chk({tag, ".rvalid"}, 32'(req_if.m_rvalid_o), 32'(!wr));
    rdata = req_if.m_rdata_o;
    $display("xfer %-12s %s addr=%0d wdata=0x%02h strb=%b rdata=0x%02h slverr=%0b",
             tag, wr ? "WR" : "RD", addr, wdata, strb, rdata, slverr);
  endtask

  task automatic wr_s(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [3:0] strb, input logic exp_err);
    logic [DW-1:0] d;
    logic          e;
    xfer(tag, 1'b1, addr, data, strb, d, e);
    chk({tag, ".slverr"}, 32'(e), 32'(exp_err));
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                    input logic exp_err);
    wr_s(tag, addr, data, 4'b0000, exp_err);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                    input logic exp_err);
    logic [DW-1:0] d;
    logic          e;
    xfer(tag, 1'b0, addr, '0, 4'b0000, d, e);
    chk({tag, ".data"}, 32'(d), 32'(exp));
    chk({tag, ".slverr"}, 32'(e), 32'(exp_err));
  endtask

  task automatic pulse_mrw(input logic [NR-1:0] m);
    @(negedge clk); mrw_done = m;
    @(negedge clk); mrw_done = '0;
  endtask

  task automatic pulse_mrr(input logic [NR-1:0] m);
    @(negedge clk); mrr_done = m;
    @(negedge clk); mrr_done = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, ".rank"}, 32'({rank_mrw, rank_mrr}), 32'h0);
    chk({tag, ".bus"}, 32'({dut.u_apb.psel, dut.u_apb.penable, dut.u_apb.pwrite}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req_if.t         = 1'b0;
    req_if.rd_wr     = 1'b0;
    req_if.strb_i    = 4'b0000;
    req_if.m_addr_i  = '0;
    req_if.m_wdata_i = '0;

    // Reset state
    #12;
    chk("rst.rank_mrw", 32'(rank_mrw), 32'h0);
    chk("rst.rank_mrr", 32'(rank_mrr), 32'h0);
    chk("rst.rdata", 32'(req_if.m_rdata_o), 32'h0);
    chk("rst.rvalid", 32'(req_if.m_rvalid_o), 32'h0);
    chk("rst.ctl", 32'({dut.u_apb.psel, dut.u_apb.penable, dut.u_apb.pwrite}), 32'h0);
    chk("rst.addr_data", 32'({dut.u_apb.paddr, dut.u_apb.pwdata, dut.u_apb.pstrb}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle.psel", 32'(dut.u_apb.psel), 32'h0);

    // Basic register write/read
    wr("mask1", 16'd3, 8'h01, 1'b0);
    rd("mask1_rd", 16'd3, 8'h01, 1'b0);

    // Single-rank MRW
    wr("mrw1", 16'd2, 8'h01, 1'b0);
    chk("mrw1.rank_mrw", 32'(rank_mrw), 32'h01);
    chk("mrw1.rank_mrr", 32'(rank_mrr), 32'h00);
    rd("mrw1_busy", 16'd2, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    pulse_mrw(8'h01);
    chk("mrw1_done.rank", 32'(rank_mrw), 32'h00);
    rd("mrw1_stat", 16'd2, 8'h04, 1'b0);

    // Command errors while idle
    wr("cmd3", 16'd2, 8'h03, 1'b1);
    chk("cmd3.rank", 32'({rank_mrw, rank_mrr}), 32'h0);
    rd("cmd3_stat", 16'd2, 8'h04, 1'b0);
    wr("mask0", 16'd3, 8'h00, 1'b0);
    wr("cmd_mask0", 16'd2, 8'h01, 1'b1);
    chk("cmd_mask0.rank", 32'({rank_mrw, rank_mrr}), 32'h0);
    wr("cmd_nop", 16'd2, 8'h00, 1'b0);

    // Two-rank MRW, busy errors, mask write in flight
    wr("mask5", 16'd3, 8'h05, 1'b0);
    wr("mrw5", 16'd2, 8'h01, 1'b0);
    chk("mrw5.rank_mrw", 32'(rank_mrw), 32'h05);
    rd("mrw5_stat", 16'd2, 8'h01, 1'b0);
    wr("busy_mrr", 16'd2, 8'h02, 1'b1);
    chk("busy_mrr.rank_mrr", 32'(rank_mrr), 32'h00);
    wr("busy_mrw", 16'd2, 8'h01, 1'b1);
    chk("busy_mrw.rank_mrw", 32'(rank_mrw), 32'h05);
    wr("mask_busy", 16'd3, 8'h02, 1'b0);
    chk("mask_busy.rank_mrw", 32'(rank_mrw), 32'h05);
    pulse_mrw(8'h01);
    chk("mrw5_r0.rank", 32'(rank_mrw), 32'h04);
    rd("mrw5_r0_stat", 16'd2, 8'h01, 1'b0);
    pulse_mrw(8'h02);
    chk("mrw5_stray.rank", 32'(rank_mrw), 32'h04);
    pulse_mrw(8'h04);
    chk("mrw5_r2.rank", 32'(rank_mrw), 32'h00);
    rd("mrw5_r2_stat", 16'd2, 8'h04, 1'b0);
    rd("mask_after", 16'd3, 8'h02, 1'b0);

    // Unmapped and read-only addresses
    wr("bad7_wr", 16'd7, 8'hFF, 1'b1);
    rd("bad7_rd", 16'd7, 8'h00, 1'b1);
    wr("ro4_wr", 16'd4, 8'hFF, 1'b0);
    rd("ro4_rd", 16'd4, 8'h00, 1'b0);

    // Scratch registers and byte strobes
    wr("scr0", 16'd0, 8'hA5, 1'b0);
    rd("scr0_rd", 16'd0, 8'hA5, 1'b0);
    wr_s("scr0_s2", 16'd0, 8'h3C, 4'b0010, 1'b0);
    rd("scr0_s2_rd", 16'd0, 8'hA5, 1'b0);
    wr_s("scr0_s1", 16'd0, 8'h3C, 4'b0001, 1'b0);
    rd("scr0_s1_rd", 16'd0, 8'h3C, 1'b0);
    wr("scr1", 16'd1, 8'h5A, 1'b0);
    rd("scr1_rd", 16'd1, 8'h5A, 1'b0);

    // Reset clears registers; then a single-rank MRR
    do_reset("rst2");
    rd("rst2_scr0", 16'd0, 8'h00, 1'b0);
    rd("rst2_mask", 16'd3, 8'h00, 1'b0);
    wr("mrr_mask", 16'd3, 8'h01, 1'b0);
    wr("mrr1", 16'd2, 8'h02, 1'b0);
    chk("mrr1.rank_mrr", 32'(rank_mrr), 32'h01);
    chk("mrr1.rank_mrw", 32'(rank_mrw), 32'h00);
    rd("mrr1_rdone0", 16'd4, 8'h00, 1'b0);
    pulse_mrr(8'h01);
    chk("mrr1_done.rank", 32'(rank_mrr), 32'h00);
    rd("mrr1_stat", 16'd2, 8'h08, 1'b0);
    rd("mrr1_rdone", 16'd4, 8'h01, 1'b0);

    // Reset mid-operation drops the request immediately
    wr("mrw_abort", 16'd2, 8'h01, 1'b0);
    chk("mrw_abort.rank", 32'(rank_mrw), 32'h01);
    do_reset("rst3");
    rd("rst3_stat", 16'd2, 8'h00, 1'b0);

    // t held for two cycles gives exactly one transfer
    n_acc = 0;
    @(negedge clk);
    req_if.t        = 1'b1;
    req_if.rd_wr    = 1'b0;
    req_if.m_addr_i = 16'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) req_if.t = 1'b0;
      if (dut.u_apb.psel && dut.u_apb.penable) n_acc++;
    end
    chk("t2.one_xfer", 32'(n_acc), 32'd1);
    $display("xfer t2_hold     RD addr=3 access_cycles=%0d", n_acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/apb_mr_bridge.md
# apb_mr_bridge

Mode-register command path: `apb_master_port` turns a simple backend request into APB3 transfers, and `apb_slave_port` decodes them into a small register file. That register file launches per-rank MRW/MRR operations and collects their done status. `apb_mr_bridge` instantiates the two, wired back-to-back on an internal APB bus; the slave runs on the master-forwarded clock and reset.

## Interface
- APB_ADDRWIDTH, 16, paddr / m_addr_i width; paddr is a word index.
- APB_DATAWIDTH, 8, data width; multiple of 8, at most 32.
- NB_RANK, 8, number of ranks; at most APB_DATAWIDTH.
- mclk_i  in  1  sole clock. Master forwards it as pclk_o; the slave uses it as pclk_i.
- mrst_ni  in  1  reset, asynchronous, active-low. Forwarded as prst_no → prst_ni.
- t  in  1  transfer request, level.
- rd_wr  in  1  1 = write, 0 = read.
- strb_i  in  4  write byte strobes.
- m_addr_i  in  APB_ADDRWIDTH  transfer address.
- m_wdata_i  in  APB_DATAWIDTH  write data.
- m_rdata_o  out  APB_DATAWIDTH  read data.
- m_rvalid_o  out  1  one-cycle pulse: m_rdata_o is valid.
- mrw_done_status_i  in  NB_RANK  per-rank MRW done pulse.
- mrr_done_status_i  in  NB_RANK  per-rank MRR done pulse.
- rank_mrw_o  out  NB_RANK  per-rank MRW request, level.
- rank_mrr_o  out  NB_RANK  per-rank MRR request, level.
- Internal APB3 bus: psel, penable, pwrite, paddr, pwdata, pstrb[3:0], pready, prdata, pslverr.

## Operation
- **Master FSM: IDLE / SETUP / ACCESS.**
  - IDLE→SETUP when t=1. On that edge, m_addr_i, m_wdata_i, rd_wr and strb_i are registered onto paddr, pwdata, pwrite and pstrb.
  - SETUP: psel=1, penable=0. Always advances to ACCESS.
  - ACCESS: psel=1, penable=1. Holds until pready=1.
  - On pready, go to SETUP if t=1 (new sample), else IDLE.
  - On a completed read, m_rdata_o ← prdata and m_rvalid_o pulses on the next cycle.
  - pslverr is ignored by the master; the transfer is still complete.
- **Slave handshake.**
  - pready_o = psel & penable (zero wait states).
  - prdata_o = read mux while psel & penable & !pwrite, else 0.
  - pslverr_o is valid only while pready_o=1.
- **Byte strobes.**
  - pstrb = 0 means all lanes are written (APB3 legacy).
  - Otherwise only the lanes with pstrb[i]=1 are updated.
- **Register map** (paddr):
  - 0: MR_ADDR, RW scratch.
  - 1: MR_DATA, RW scratch.
  - 2: CMD/STATUS.
    - Write bit0 = start MRW, bit1 = start MRR.
    - Read bit0 = mrw_busy, bit1 = mrr_busy, bit2 = mrw_done (sticky), bit3 = mrr_done (sticky).
  - 3: RANK_MASK, RW, NB_RANK bits.
  - 4: MRR_RANK_DONE, RO; per-rank done bits of the last MRR.
  - Any other address: pslverr=1, no write side effect, read data 0.
- **MRW start** (write to 2 with value 1):
  - rank_mrw_o ← RANK_MASK, mrw_busy=1, mrw_done=0.
  - Each mrw_done_status_i[r] sampled high clears rank_mrw_o[r].
  - When rank_mrw_o reaches 0: mrw_busy=0, mrw_done=1.
- **MRR start** (value 2): same sequence with the rank_mrr_o / mrr_* signals. Each done bit also sets MRR_RANK_DONE[r]; MRR_RANK_DONE is cleared at start.
- **Command errors** → pslverr, no action:
  - value 3 (both bits set);
  - RANK_MASK = 0;
  - any command while mrw_busy or mrr_busy.
- Value 0 written to address 2 is a no-op, no error.
- Done pulses for ranks not currently requested are ignored.
- Writes to RANK_MASK while busy are accepted but do not affect the operation in flight.

## Timing
- Reset (async, while mrst_ni=0):
  - all registers 0;
  - FSM in IDLE;
  - psel, penable, pwrite, paddr, pwdata, pstrb = 0;
  - m_rdata_o = 0, m_rvalid_o = 0;
  - rank_mrw_o = 0, rank_mrr_o = 0.
- Reset mid-transfer or mid-operation aborts immediately; requests drop without waiting for done.
- A transfer takes exactly 2 cycles: SETUP, then ACCESS with pready.
- t held for 2 cycles produces exactly one transfer.
- A register write takes effect at the ACCESS clock edge. rank_* rises the cycle after that edge.
- A done pulse of ≥1 cycle clears the matching rank bit at the next edge. Status updates in the same edge.
- A read in the cycle after a write returns the new value (no hazard).

## Test plan
- Reset, t=0 → all outputs 0; no psel activity.
- Write 1 to address 3, then read 3 with strb=0 → m_rvalid_o pulse with m_rdata_o=0x01; pslverr=0.
- RANK_MASK=0x01, write 1 to address 2:
  - rank_mrw_o=0x01 the cycle after ACCESS;
  - 30 ns later a 10 ns pulse on mrw_done_status_i[0] → rank_mrw_o=0;
  - read address 2 → 0x04.
- Write 2 to address 2 → rank_mrr_o=0x01; after mrr_done_status_i[0] pulse, read 2 → 0x08 and read 4 → 0x01.
- RANK_MASK=0x05, MRW start, done pulses for rank 0 then rank 2 → busy stays 1 after the first pulse; done=1 only after the second.
- Error cases, each → pslverr=1 and no rank request:
  - write 3 to address 2;
  - any command while busy;
  - any access to address 7.
